hazard_unit: RTL
================

# hazard_unit

Pipeline hazard controller for the 5-stage core, the stall/flush side of the operand-bypass path. The bypass network resolves RAW dependences by muxing results from MEM/WB into EX. This block handles every hazard that muxing cannot resolve:
- load-use dependences, by inserting one bubble;
- multi-cycle multiplies in EX, by freezing the front end;
- taken branches/jumps resolved in EX, by flushing IF/ID and ID/EX.

It also keeps stall and flush performance counters.

## Interface
Parameters:
- MUL_LAT, 4: cycles a multiply occupies EX; legal range 2..16.
- CWIDTH, 32: width of performance counters.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rstn  in  1  reset, asynchronous and active-low.
- id_rs1_id  in  5  rs1 index of the instruction in ID.
- id_rs2_id  in  5  rs2 index of the instruction in ID.
- id_use_rs1  in  1  ID instruction reads rs1.
- id_use_rs2  in  1  ID instruction reads rs2.
- ex_rdst_id  in  5  destination index of the instruction in EX.
- ex_we_regfile  in  1  EX instruction writes the register file.
- ex_mem_read  in  1  EX instruction is a load.
- ex_is_mul  in  1  EX instruction is a multi-cycle multiply.
- ex_branch_taken  in  1  branch/jump in EX resolved taken.
- cnt_clear  in  1  synchronous clear of both counters.
- pc_stall  out  1  hold PC.
- if_id_stall  out  1  hold IF/ID register.
- id_ex_stall  out  1  hold ID/EX register.
- id_ex_flush  out  1  load bubble (NOP) into ID/EX.
- if_id_flush  out  1  load NOP into IF/ID.
- ex_mem_bubble  out  1  load NOP into EX/MEM.
- mul_done  out  1  multiply result valid in EX this cycle.
- stall_cycles  out  CWIDTH  count of cycles with pc_stall=1.
- flush_events  out  CWIDTH  count of cycles with if_id_flush=1.

## Operation
- The multiply FSM has two states, IDLE and BUSY, with a 4-bit counter `mcnt`.
  - IDLE with ex_is_mul=1: this is cycle 1 of MUL_LAT. Assert pc_stall, if_id_stall, id_ex_stall and ex_mem_bubble. Next state BUSY, mcnt←1.
  - BUSY with mcnt < MUL_LAT-1: same four stall outputs asserted; mcnt←mcnt+1.
  - BUSY with mcnt = MUL_LAT-1: mul_done=1 and no stall outputs, so the pipeline advances. Next state IDLE, mcnt←0.
  - A back-to-back multiply is handled with no special case: the next one enters EX in the following cycle and sees IDLE with ex_is_mul=1.
- Load-use hazard. It is active only in IDLE with ex_is_mul=0, when all of the following hold:
  - ex_mem_read=1, ex_we_regfile=1 and ex_rdst_id≠0;
  - (id_use_rs1 and id_rs1_id=ex_rdst_id) or (id_use_rs2 and id_rs2_id=ex_rdst_id).

  Response: pc_stall=1, if_id_stall=1, id_ex_flush=1. id_ex_stall stays 0.
- Taken branch, in IDLE with ex_is_mul=0: if_id_flush=1 and id_ex_flush=1. No stall is asserted.
- Priority, highest first: multiply freeze, then taken branch, then load-use.
  - ex_branch_taken is ignored whenever a multiply occupies EX.
  - Branch and load-use in the same cycle: flush only, no stall. The dependent instruction is discarded.
- A reference to register x0 never causes a stall.
- Counters:
  - stall_cycles increments each cycle pc_stall=1.
  - flush_events increments each cycle if_id_flush=1.
  - Both saturate at all-ones.
  - cnt_clear=1 sets both to 0 next edge; clear takes priority over increment.

## Timing
- All hazard outputs are combinational from the current inputs and FSM state, so they take effect at the next clock edge. Counters and FSM are registered.
- While rstn=0, regardless of the other inputs:
  - FSM=IDLE, mcnt=0, stall_cycles=0, flush_events=0;
  - every 1-bit output is forced to 0.
- Reset deassertion is synchronized externally. The first edge after release evaluates normally.
- Multiply latency: MUL_LAT cycles in EX, of which MUL_LAT-1 are stall cycles. mul_done is high for exactly 1 cycle.
- Load-use costs 1 cycle: the dependence is gone the next cycle, because the load has moved to MEM and the bypass path covers it.
- Branch penalty: 2 flushed instructions, 1 flush cycle.
- Reset asserted mid-multiply: the FSM returns to IDLE immediately and no mul_done is produced.

## Test plan
- Load-use: ex_mem_read=1, ex_we_regfile=1, ex_rdst_id=5; id_rs2_id=5, id_use_rs2=1 -> 1 cycle of pc_stall=if_id_stall=id_ex_flush=1; stall_cycles=1. Repeating with rdst=0 -> no stall.
- Multiply at MUL_LAT=4: ex_is_mul=1 held while stalled -> stalls and ex_mem_bubble for 3 cycles, then mul_done=1 in cycle 4 with no stall. Two consecutive multiplies -> 6 stall cycles total, mul_done twice.
- Branch: ex_branch_taken=1 together with a matching load-use -> if_id_flush=id_ex_flush=1, pc_stall=0, flush_events increments by 1.
- Branch during multiply: ex_branch_taken=1 in BUSY -> ignored, no flush, multiply completes on schedule.
- Reset mid-multiply: rstn low in BUSY cycle 2 -> all outputs 0 immediately. After release with ex_is_mul=0 -> IDLE, no mul_done.
- Counter saturation: with CWIDTH=4, 20 stall cycles -> stall_cycles=15. cnt_clear together with a stall -> 0 next cycle.

Source files
------------

// File: rtl/hazard_unit.sv
// hazard_unit: stall/flush control for load-use, multi-cycle multiply and taken branches, with perf counters
module hazard_unit #(
  parameter int MUL_LAT = 4,
  parameter int CWIDTH  = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [4:0]        id_rs1_id,
  input  logic [4:0]        id_rs2_id,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [4:0]        ex_rdst_id,
  input  logic              ex_we_regfile,
  input  logic              ex_mem_read,
  input  logic              ex_is_mul,
  input  logic              ex_branch_taken,
  input  logic              cnt_clear,
  output logic              pc_stall,
  output logic              if_id_stall,
  output logic              id_ex_stall,
  output logic              id_ex_flush,
  output logic              if_id_flush,
  output logic              ex_mem_bubble,
  output logic              mul_done,
  output logic [CWIDTH-1:0] stall_cycles,
  output logic [CWIDTH-1:0] flush_events
);
  typedef enum logic {IDLE, BUSY} state_t;
  localparam logic [3:0] LAST = 4'(MUL_LAT - 1);
  state_t     state;
  logic [3:0] mcnt;
  logic       mul_stall, free, br, lu;
  always_comb begin
    mul_stall     = rstn && ((state == IDLE && ex_is_mul) || (state == BUSY && mcnt < LAST));
    mul_done      = rstn && state == BUSY && mcnt == LAST;
    free          = rstn && state == IDLE && !ex_is_mul;
    br            = free && ex_branch_taken;
    lu            = free && !ex_branch_taken && ex_mem_read && ex_we_regfile && ex_rdst_id != 5'd0 &&
                    ((id_use_rs1 && id_rs1_id == ex_rdst_id) || (id_use_rs2 && id_rs2_id == ex_rdst_id));
    pc_stall      = mul_stall || lu;
    if_id_stall   = mul_stall || lu;
    id_ex_stall   = mul_stall;
    ex_mem_bubble = mul_stall;
    id_ex_flush   = br || lu;
    if_id_flush   = br;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      mcnt  <= '0;
    end else if (state == IDLE) begin
      if (ex_is_mul) begin
        state <= BUSY;
        mcnt  <= 4'd1;
      end
    end else if (mcnt < LAST) begin
      mcnt <= mcnt + 4'd1;
    end else begin
      state <= IDLE;
      mcnt  <= '0;
    end
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      stall_cycles <= cnt_clear ? '0 : (pc_stall && !(&stall_cycles)) ? stall_cycles + 1'b1 : stall_cycles;
      flush_events <= cnt_clear ? '0 : (if_id_flush && !(&flush_events)) ? flush_events + 1'b1 : flush_events;
    end
  end
endmodule
